// File: rtl/accum_quant.sv
// Accumulates CHUNKS partial sums per vector (bias on the first chunk),
// then rounds, shifts and saturates the total into a one-deep output.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        partial-sum handshake carrying dp and bias
//   out_valid/out_ready      result handshake carrying out_data, out_sat
// Build option: define ACCUM_QUANT_RELU_EN to zero negative results
// before saturation.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module accum_quant #(
  parameter int CHUNKS     = 4,
  parameter int SHIFT      = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ACC_WIDTH  = `ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_WIDTH-1:0]  dp,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_sat
);

  localparam int AW = ACC_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  // Half of one output LSB; zero when SHIFT is 0.
  localparam logic [AW:0] RND = ((AW+1)'(1) << SHIFT) >> 1;

  localparam logic signed [AW:0] MAXV =
    {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] MINV =
    {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic                 accept;
  logic                 last;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] sum;
  logic signed [AW:0]   pre;
  logic signed [AW:0]   r;
  logic signed [AW:0]   rr;
  logic signed [DW-1:0] q_data;
  logic                 q_sat;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    accept = in_valid && in_ready;
    last   = (cnt_q == LAST);
    base   = (cnt_q == '0) ? bias : acc_q;
    sum    = base + dp;

    // One extra bit so the rounding add cannot overflow.
    pre = {sum[AW-1], sum} + RND;
    r   = pre >>> SHIFT;

`ifdef ACCUM_QUANT_RELU_EN
    rr = r[AW] ? '0 : r;
`else
    rr = r;
`endif

    q_sat  = 1'b0;
    q_data = rr[DW-1:0];
    if (rr > MAXV) begin
      q_data = MAXV[DW-1:0];
      q_sat  = 1'b1;
    end else if (rr < MINV) begin
      q_data = MINV[DW-1:0];
      q_sat  = 1'b1;
    end

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      acc_d = sum;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        out_valid_d = 1'b1;
        out_data_d  = q_data;
        out_sat_d   = q_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_accum_quant.sv
// Scoreboard bench for accum_quant: random and directed vectors are
// checked against an arithmetic model of round/shift/saturate.
module tb_accum_quant;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] dp;
  logic signed [31:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_sat;

  int checks = 0;
  int fails  = 0;
  int mode   = 0;

  logic [8:0] exp_q[$];

  accum_quant #(
    .CHUNKS(4), .SHIFT(4), .DATA_WIDTH(8), .ACC_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dp(dp), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: total -> round half up, divide by 16, optional ReLU,
  // clamp to int8. Returns {sat, data}.
  function automatic logic [8:0] model(logic signed [31:0] s);
    longint r;
    logic   sat;
    r   = (longint'(s) + 8) >>> 4;
`ifdef ACCUM_QUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    if (r < -128) begin r = -128; sat = 1'b1; end
    return {sat, 8'(r)};
  endfunction

  // out_ready policy: 0 always high, 1 random, 2 always low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: out_ready = 1'b1;
        2: out_ready = 1'b0;
        default: out_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: any presented result must match the queue head.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: got %0d expected none",
                   out_data);
        end else begin
          e = exp_q[0];
          chk("out_data", longint'(out_data), longint'($signed(e[7:0])));
          chk("out_sat", longint'(out_sat), longint'(e[8]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_chunk(logic signed [31:0] b,
                            logic signed [31:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    bias     = b;
    dp       = d;
    n        = 0;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
    end
    @(posedge clk);
  endtask

  task automatic idle(int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_vec(logic signed [31:0] b,
                          logic signed [31:0] d0,
                          logic signed [31:0] d1,
                          logic signed [31:0] d2,
                          logic signed [31:0] d3,
                          bit gaps);
    logic signed [31:0] d[4];
    logic signed [31:0] s;
    d = '{d0, d1, d2, d3};
    s = b;
    for (int i = 0; i < 4; i++) begin
      send_chunk((i == 0) ? b : $signed($urandom), d[i]);
      s = s + d[i];
      if (gaps && ($urandom % 3 == 0) && i < 3) idle($urandom % 3);
    end
    exp_q.push_back(model(s));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  function automatic logic signed [31:0] rnd_dp();
    case ($urandom % 3)
      0: return $signed(32'($urandom_range(2000))) - 1000;
      1: return $signed(32'($urandom_range(40000))) - 20000;
      default: return $signed($urandom);
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    dp       = '0;
    bias     = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Sum path and single-cycle valid pulse
    send_chunk(16, 10);
    send_chunk(0, 20);
    send_chunk(0, 30);
    #1;
    chk("pulse_before", out_valid, 0);
    send_chunk(0, 40);
    exp_q.push_back(model(116));
    #1;
    chk("pulse_on", out_valid, 1);
    chk("sum_data", out_data, 7);
    idle(0);
    @(posedge clk);
    #1;
    chk("pulse_off", out_valid, 0);

    // Saturation and negative rounding
    send_vec(0, 1000, 1000, 1000, 1000, 0);
    send_vec(0, -1000, -1000, -1000, -1000, 0);
    send_vec(0, -100, -100, -100, -100, 0);
    idle(2);
    drain();

    // Backpressure
    mode = 2;
    idle(1);
    send_vec(16, 10, 20, 30, 40, 0);
    @(negedge clk);
    in_valid = 1'b1;
    bias     = 3;
    dp       = 16;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, 7);
      @(negedge clk);
    end
    mode = 0;
    @(negedge clk);
    #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 1);
    @(posedge clk);
    send_chunk(99, 16);
    send_chunk(-7, 16);
    send_chunk(1, 16);
    exp_q.push_back(model(3 + 64));
    idle(1);
    drain();

    // Reset mid-vector discards partial accumulation
    send_chunk(5, 1);
    send_chunk(0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    send_vec(0, 16, 16, 16, 16, 0);
    idle(1);
    drain();

    // Random traffic with random backpressure and gaps
    mode = 1;
    for (int v = 0; v < 40; v++) begin
      send_vec($signed($urandom_range(400)) - 200,
               rnd_dp(), rnd_dp(), rnd_dp(), rnd_dp(), 1);
    end
    idle(0);
    mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/accum_quant.md
ACCUM_QUANT -- requirements
Module: accum_quant

Interface
REQ-001 The module SHALL have parameter CHUNKS, default 4, giving the number of dot-product partial sums per output element (>=1).
REQ-002 The module SHALL have parameter SHIFT, default 4, giving the arithmetic right-shift applied to the accumulator (0..ACC_WIDTH-1).
REQ-003 The module SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, giving the output element width.
REQ-004 The module SHALL have parameter ACC_WIDTH, default `ACC_WIDTH, giving the partial-sum and accumulator width.
REQ-005 The module SHALL have the following ports, one clock, with a synchronous active-high reset:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  in_valid  input  1  partial sum present
  in_ready  output  1  partial sum accepted when in_valid and in_ready are both high
  dp  input  ACC_WIDTH signed  dot-product partial sum
  bias  input  ACC_WIDTH signed  bias, sampled only on the first chunk of a vector
  out_valid  output  1  quantized result present
  out_ready  input  1  downstream accepts the result
  out_data  output  DATA_WIDTH signed  quantized result
  out_sat  output  1  out_data was clamped

Function
REQ-006 A chunk counter cnt SHALL count 0..CHUNKS-1 and increment on every accepted partial sum.
REQ-007 On acceptance with cnt==0, acc SHALL load bias+dp; otherwise acc SHALL load acc+dp. Addition SHALL wrap modulo 2^ACC_WIDTH.
REQ-008 On acceptance with cnt==CHUNKS-1, cnt SHALL return to 0, and the final sum (acc+dp, or bias+dp when CHUNKS==1) SHALL be quantized and registered into out_data/out_sat with out_valid=1 on the next cycle (latency 1 cycle after the last chunk).
REQ-009 Quantization SHALL be computed in ACC_WIDTH+1 bits: r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (round half up). r SHALL then pass through the ReLU stage (REQ-016). It SHALL then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], with out_sat=1 only when the value was clamped.
REQ-010 The output register SHALL be one deep. in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-011 out_valid SHALL clear on out_valid && out_ready, unless a new result completes in the same cycle, in which case out_valid stays 1 and out_data/out_sat take the new result.
REQ-012 While out_valid && !out_ready, out_data and out_sat SHALL hold stable, and no partial sum SHALL be accepted.
REQ-013 A partial sum not accepted (in_valid && !in_ready) SHALL leave acc and cnt unchanged.

Reset
REQ-014 When rst is high at a clock edge, the following SHALL apply:
  out_valid = 0, out_data = 0, out_sat = 0, cnt = 0, acc = 0.
  Any partially accumulated vector is discarded.
  in_ready reads 1 in the cycle following reset.
REQ-015 A reset mid-vector SHALL cause the next accepted chunk to be treated as cnt==0, so that bias is re-sampled.

Configuration
REQ-016 With macro ACCUM_QUANT_RELU_EN defined, negative r SHALL be forced to 0 before saturation, and out_sat SHALL NOT be set by this clamp. Without the macro, negative values pass through to signed saturation unchanged.

Verification (DATA_WIDTH=8, ACC_WIDTH=32, CHUNKS=4, SHIFT=4, out_ready=1 unless stated)
REQ-017 Sum path: bias=16, dp=10,20,30,40 on consecutive cycles -> acc=116, out_data=7, out_sat=0, out_valid high exactly the cycle after the 4th accept, for one cycle.
REQ-018 Saturation: bias=0, dp=1000 x4 -> out_data=127, out_sat=1. Also bias=0, dp=-1000 x4 without RELU_EN -> out_data=-128, out_sat=1.
REQ-019 Negative rounding: bias=0, dp=-100 x4 (sum -400) -> out_data=-25, out_sat=0 without ACCUM_QUANT_RELU_EN; out_data=0, out_sat=0 with it.
REQ-020 Backpressure: hold out_ready=0 after a result while the next vector is driven -> in_ready=0, out_data is stable, no chunks are consumed. Raise out_ready -> the first chunk is accepted in the same cycle as the result handshake, and the second result equals the expected value.
REQ-021 Reset mid-vector: accept 2 chunks (bias=5, dp=1,1), assert rst for 1 cycle, then send bias=0, dp=16 x4 -> out_data=4, with no contribution from the discarded chunks.
